// File: rtl/isp_tile_walker.sv
// isp_tile_walker
//
// Per-triangle pixel walker for the ISP rasteriser. The triangle bounding box
// is clipped to the current tile, and the remaining rectangle is visited in
// row-major order. The current pixel goes to the combinational plane
// interpolator as fixed-point x_ps/y_ps. The interpolated value that comes
// back is captured with the pixel coordinates into a single output register
// that feeds a valid/ready stream.
//
// Ports
//   clock, reset_n           clock; asynchronous active-low reset
//   start                    one-cycle walk request, accepted only in IDLE
//   tile_x/tile_y            tile origin, latched on accepted start
//   x_min/x_max/y_min/y_max  inclusive triangle bbox, latched on accepted start
//   busy, done               not-idle flag; one-cycle completion pulse
//   x_ps/y_ps                current pixel in interpolator fixed point
//   interp_in                interpolator result for x_ps/y_ps
//   out_valid/out_ready      output stream handshake
//   out_x/out_y/out_z        emitted pixel and its interpolated value
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// CLIP  | clipped range is evaluated; load first pixel or skip walk
// WALK  | one pixel captured per advance, stepping row-major
// DRAIN | last pixel is held until the stream has taken it
// DONE  | done pulse, then back to IDLE

module isp_tile_walker #(
  parameter int FRAC_BITS = 8,
  parameter int TILE_W    = 32,
  parameter int TILE_H    = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [10:0]        tile_x,
  input  logic [10:0]        tile_y,
  input  logic [10:0]        x_min,
  input  logic [10:0]        x_max,
  input  logic [10:0]        y_min,
  input  logic [10:0]        y_max,
  output logic               busy,
  output logic               done,
  output logic signed [31:0] x_ps,
  output logic signed [31:0] y_ps,
  input  logic signed [31:0] interp_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [10:0]        out_x,
  output logic [10:0]        out_y,
  output logic signed [31:0] out_z
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLIP,
    S_WALK,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [11:0] TileWm1 = 12'(TILE_W - 1);
  localparam logic [11:0] TileHm1 = 12'(TILE_H - 1);

  state_t state_q, state_d;

  logic [10:0] tile_x_q, tile_x_d;
  logic [10:0] tile_y_q, tile_y_d;
  logic [10:0] x_min_q, x_min_d;
  logic [10:0] x_max_q, x_max_d;
  logic [10:0] y_min_q, y_min_d;
  logic [10:0] y_max_q, y_max_d;
  logic [10:0] cur_x_q, cur_x_d;
  logic [10:0] cur_y_q, cur_y_d;
  logic [10:0] out_x_q, out_x_d;
  logic [10:0] out_y_q, out_y_d;
  logic [31:0] out_z_q, out_z_d;
  logic        out_valid_q, out_valid_d;

  // Clip range, evaluated from the latched bbox. The tile end is formed in
  // 12 bits so that a tile at the top of the 11-bit space cannot wrap to 0.
  logic [11:0] tile_xe, tile_ye;
  logic [11:0] xs12, xe12, ys12, ye12;
  logic        clip_empty;
  logic [10:0] xs, xe, ys, ye;

  always_comb begin
    tile_xe    = {1'b0, tile_x_q} + TileWm1;
    tile_ye    = {1'b0, tile_y_q} + TileHm1;
    xs12       = (tile_x_q > x_min_q) ? {1'b0, tile_x_q} : {1'b0, x_min_q};
    ys12       = (tile_y_q > y_min_q) ? {1'b0, tile_y_q} : {1'b0, y_min_q};
    xe12       = (tile_xe < {1'b0, x_max_q}) ? tile_xe : {1'b0, x_max_q};
    ye12       = (tile_ye < {1'b0, y_max_q}) ? tile_ye : {1'b0, y_max_q};
    clip_empty = (xs12 > xe12) || (ys12 > ye12);
    // Every value here is either an 11-bit bbox bound or a tile end that
    // lost the min against one, so bit 11 is always clear.
    xs         = xs12[10:0];
    xe         = xe12[10:0];
    ys         = ys12[10:0];
    ye         = ye12[10:0];
  end

  logic advance;
  assign advance = (state_q == S_WALK) && (!out_valid_q || out_ready);

  always_comb begin
    state_d     = state_q;
    tile_x_d    = tile_x_q;
    tile_y_d    = tile_y_q;
    x_min_d     = x_min_q;
    x_max_d     = x_max_q;
    y_min_d     = y_min_q;
    y_max_d     = y_max_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_z_d     = out_z_q;
    out_valid_d = out_valid_q;
    done        = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          tile_x_d = tile_x;
          tile_y_d = tile_y;
          x_min_d  = x_min;
          x_max_d  = x_max;
          y_min_d  = y_min;
          y_max_d  = y_max;
          state_d  = S_CLIP;
        end
      end
      S_CLIP: begin
        // An empty clip passes through DRAIN, where the output register is
        // already empty. This adds one settle cycle before DONE, which is
        // the same spacing a walk has after its last handshake.
        if (clip_empty) begin
          state_d = S_DRAIN;
        end else begin
          cur_x_d = xs;
          cur_y_d = ys;
          state_d = S_WALK;
        end
      end
      S_WALK: begin
        if (advance) begin
          out_x_d     = cur_x_q;
          out_y_d     = cur_y_q;
          out_z_d     = interp_in;
          out_valid_d = 1'b1;
          if (cur_x_q == xe) begin
            if (cur_y_q == ye) begin
              state_d = S_DRAIN;
            end else begin
              cur_x_d = xs;
              cur_y_d = cur_y_q + 11'd1;
            end
          end else begin
            cur_x_d = cur_x_q + 11'd1;
          end
        end
      end
      S_DRAIN: begin
        if (!out_valid_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      tile_x_q    <= '0;
      tile_y_q    <= '0;
      x_min_q     <= '0;
      x_max_q     <= '0;
      y_min_q     <= '0;
      y_max_q     <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_z_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tile_x_q    <= tile_x_d;
      tile_y_q    <= tile_y_d;
      x_min_q     <= x_min_d;
      x_max_q     <= x_max_d;
      y_min_q     <= y_min_d;
      y_max_q     <= y_max_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_z_q     <= out_z_d;
      out_valid_q <= out_valid_d;
    end
  end

  logic [31:0] cur_x_ext, cur_y_ext;
  assign cur_x_ext = {21'b0, cur_x_q};
  assign cur_y_ext = {21'b0, cur_y_q};
  assign x_ps      = cur_x_ext << FRAC_BITS;
  assign y_ps      = cur_y_ext << FRAC_BITS;

  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_z     = out_z_q;

endmodule

// File: tb/tb_isp_tile_walker.sv
// Directed bench for isp_tile_walker. A small plane function stands in for
// the interpolator. The expected pixel order comes from scanning every pixel
// of the tile and keeping the ones inside the bbox. Pixel counts, last
// pixels and edge timing are hand-computed in the vector table.

module tb_isp_tile_walker;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic [10:0]        tile_x = '0, tile_y = '0;
  logic [10:0]        x_min = '0, x_max = '0, y_min = '0, y_max = '0;
  logic               busy, done;
  logic signed [31:0] x_ps, y_ps, interp_in, out_z;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [10:0]        out_x, out_y;

  isp_tile_walker #(.FRAC_BITS(8), .TILE_W(32), .TILE_H(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .tile_x(tile_x), .tile_y(tile_y),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .busy(busy), .done(done), .x_ps(x_ps), .y_ps(y_ps),
    .interp_in(interp_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z)
  );

  always #5 clock = ~clock;

  assign interp_in = 3 * x_ps - 2 * y_ps + 32'sd1000;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_z(input int x, input int y);
    return 3 * (x << 8) - 2 * (y << 8) + 1000;
  endfunction

  typedef struct {
    int tx, ty, xmin, xmax, ymin, ymax;
    int npix, lx, ly;
  } vec_t;

  vec_t vecs[7];
  int   exp_x[$];
  int   exp_y[$];

  // mode 0: out_ready=1; mode 1: out_ready pattern 1,0,0,1; inject: a
  // conflicting start during WALK, which must be ignored.
  task automatic run_walk(input vec_t v, input bit bp, input bit inject);
    int n, idx, stalls, first_v, done_e, lx, ly, exp_done;
    bit prev_stall, got_done;
    logic [10:0] hx, hy;
    logic signed [31:0] hz;
    exp_x.delete();
    exp_y.delete();
    for (int ty = 0; ty < 32; ty++) begin
      for (int tx = 0; tx < 32; tx++) begin
        int px, py;
        px = v.tx + tx;
        py = v.ty + ty;
        if (px >= v.xmin && px <= v.xmax && py >= v.ymin && py <= v.ymax &&
            px < 2048 && py < 2048) begin
          exp_x.push_back(px);
          exp_y.push_back(py);
        end
      end
    end
    idx = 0; stalls = 0; first_v = -1; done_e = -1; lx = -1; ly = -1;
    prev_stall = 0; got_done = 0; hx = '0; hy = '0; hz = '0;

    @(negedge clock);
    tile_x = 11'(v.tx); tile_y = 11'(v.ty);
    x_min = 11'(v.xmin); x_max = 11'(v.xmax);
    y_min = 11'(v.ymin); y_max = 11'(v.ymax);
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = cyc;
    check("busy_after_start", busy, 1);

    for (int k = 0; k < 4000; k++) begin
      if (inject && k == 3) begin
        start = 1'b1;
        tile_x = '0; tile_y = '0;
        x_min = '0; x_max = 11'd2047; y_min = '0; y_max = 11'd2047;
      end else if (inject && k == 4) begin
        start = 1'b0;
      end
      if (bp) out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      if (prev_stall) begin
        check("stall_hold_x", out_x, hx);
        check("stall_hold_y", out_y, hy);
        check("stall_hold_z", out_z, hz);
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid && out_ready) begin
        if (idx < exp_x.size()) begin
          check("pix_x", out_x, exp_x[idx]);
          check("pix_y", out_y, exp_y[idx]);
          check("pix_z", out_z, model_z(exp_x[idx], exp_y[idx]));
        end
        idx++;
        lx = out_x; ly = out_y;
        prev_stall = 0;
      end else if (out_valid) begin
        stalls++;
        prev_stall = 1;
        hx = out_x; hy = out_y; hz = out_z;
      end else begin
        prev_stall = 0;
      end
      if (done) begin
        done_e = cyc;
        got_done = 1;
        break;
      end
      @(negedge clock);
    end

    start = 1'b0;
    check("done_seen", got_done, 1);
    check("handshakes", idx, v.npix);
    exp_done = (v.npix == 0) ? n + 2 : n + v.npix + 3 + stalls;
    check("done_edge", done_e, exp_done);
    if (v.npix > 0) begin
      check("first_valid_edge", first_v, n + 2);
      check("last_x", lx, v.lx);
      check("last_y", ly, v.ly);
    end else begin
      check("no_valid", first_v, -1);
    end
    @(negedge clock);
    check("done_one_cycle", done, 0);
    check("busy_low_after_done", busy, 0);
    out_ready = 1'b1;
  endtask

  initial begin
    //           tx    ty    xmin  xmax  ymin  ymax  npix  lx    ly
    vecs[0] = '{0,    0,    0,    100,  0,    100,  1024, 31,   31};
    vecs[1] = '{32,   64,   40,   45,   70,   71,   12,   45,   71};
    vecs[2] = '{0,    0,    50,   60,   50,   60,   0,    -1,   -1};
    vecs[3] = '{2016, 2016, 2040, 2047, 2040, 2047, 64,   2047, 2047};
    vecs[4] = '{64,   32,   60,   66,   30,   33,   6,    66,   33};
    vecs[5] = '{0,    0,    31,   31,   31,   31,   1,    31,   31};
    vecs[6] = '{32,   0,    0,    31,   0,    5,    0,    -1,   -1};

    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_x_ps", x_ps, 0);
    check("rst_out_z", out_z, 0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 7; i++) run_walk(vecs[i], 1'b0, 1'b0);

    // back-pressure on a 2x2 walk
    run_walk('{0, 0, 4, 5, 4, 5, 4, 5, 5}, 1'b1, 1'b0);

    // a start during WALK must not disturb the partial-clip walk
    run_walk(vecs[1], 1'b0, 1'b1);

    // asynchronous reset in the middle of a full-tile walk
    @(negedge clock);
    tile_x = '0; tile_y = '0;
    x_min = '0; x_max = 11'd100; y_min = '0; y_max = 11'd100;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    check("pre_reset_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_valid", out_valid, 0);
    check("arst_x_ps", x_ps, 0);
    check("arst_y_ps", y_ps, 0);
    check("arst_out_x", out_x, 0);
    check("arst_out_y", out_y, 0);
    check("arst_out_z", out_z, 0);
    repeat (3) begin
      @(negedge clock);
      check("arst_no_done", done, 0);
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("post_reset_idle", busy, 0);
      check("post_reset_no_done", done, 0);
    end

    // walker recovers normally after the abandoned walk
    run_walk(vecs[4], 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
